// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline front end (PC, IF/ID, ID/EX).
// Define PIPE_HAZARD_PERF_EN to build the saturating stall/flush performance counters.
module pipeline_hazard_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  IFID_rs,
  input  logic [4:0]  IFID_rt,
  input  logic        IFID_usesrt,
  input  logic [2:0]  IFID_pcsrc,
  input  logic        branch_taken,
  input  logic        IDEX_memrd,
  input  logic        IDEX_regwr,
  input  logic [4:0]  IDEX_wa,
  input  logic        EXMEM_memrd,
  input  logic [4:0]  EXMEM_rd,
  input  logic        exc_req,
  output logic        PC_wr,
  output logic        IFID_wr,
  output logic        IFID_flush,
  output logic        IDEX_flush,
  output logic        EXMEM_flush,
  output logic        exc_ack,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  typedef enum logic {RUN, HOLD} state_t;

  state_t     state_q, state_d;
  logic [1:0] rem_q, rem_d;
  logic       exc_prev_q;
  logic       idex_hit, exmem_hit, is_ctrl, ctrl_flush, exc_fire;
  logic [1:0] need;

  assign idex_hit  = (IDEX_wa != 5'd0) &&
                     ((IDEX_wa == IFID_rs) || (IFID_usesrt && (IDEX_wa == IFID_rt)));
  assign exmem_hit = (EXMEM_rd != 5'd0) &&
                     ((EXMEM_rd == IFID_rs) || (IFID_usesrt && (EXMEM_rd == IFID_rt)));
  assign is_ctrl    = (IFID_pcsrc == 3'b001) || (IFID_pcsrc == 3'b011);
  assign ctrl_flush = (IFID_pcsrc == 3'b010) || (IFID_pcsrc == 3'b011) ||
                      ((IFID_pcsrc == 3'b001) && branch_taken);
  // A held request is serviced once; only its rising edge triggers the flush.
  assign exc_fire   = exc_req && !exc_prev_q;

  // Rules are applied in ascending order so the last hit yields the maximum.
  always_comb begin
    need = 2'd0;
    if (IDEX_memrd && idex_hit)                             need = 2'd1;
    if (is_ctrl && IDEX_regwr && !IDEX_memrd && idex_hit)   need = 2'd1;
    if (is_ctrl && EXMEM_memrd && exmem_hit)                need = 2'd1;
    if (is_ctrl && IDEX_memrd && idex_hit)                  need = 2'd2;
  end

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    PC_wr       = 1'b1;
    IFID_wr     = 1'b1;
    IFID_flush  = 1'b0;
    IDEX_flush  = 1'b0;
    EXMEM_flush = 1'b0;
    exc_ack     = 1'b0;
    if (reset) begin
      PC_wr       = 1'b0;
      IFID_wr     = 1'b0;
      IFID_flush  = 1'b1;
      IDEX_flush  = 1'b1;
      EXMEM_flush = 1'b1;
      state_d     = RUN;
      rem_d       = 2'd0;
    end else if (exc_fire) begin
      IFID_wr     = 1'b0;
      IFID_flush  = 1'b1;
      IDEX_flush  = 1'b1;
      EXMEM_flush = 1'b1;
      exc_ack     = 1'b1;
      state_d     = RUN;
      rem_d       = 2'd0;
    end else if (state_q == HOLD) begin
      PC_wr      = 1'b0;
      IFID_wr    = 1'b0;
      IDEX_flush = 1'b1;
      rem_d      = rem_q - 2'd1;
      if (rem_d == 2'd0) state_d = RUN;
    end else if (need != 2'd0) begin
      // The control-transfer flush is deferred to the first RUN cycle after the stall.
      PC_wr      = 1'b0;
      IFID_wr    = 1'b0;
      IDEX_flush = 1'b1;
      if (need == 2'd2) begin
        state_d = HOLD;
        rem_d   = 2'd1;
      end
    end else begin
      IFID_flush = ctrl_flush;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= RUN;
      rem_q      <= 2'd0;
      exc_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      exc_prev_q <= exc_req;
    end
  end

`ifdef PIPE_HAZARD_PERF_EN
  logic [15:0] stall_cnt_q, flush_cnt_q;

  // Outside reset, PC_wr is low only on stall cycles (an exception loads the vector).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= 16'h0;
      flush_cnt_q <= 16'h0;
    end else begin
      if (!PC_wr && (stall_cnt_q != 16'hFFFF)) stall_cnt_q <= stall_cnt_q + 16'd1;
      if (IFID_flush && (flush_cnt_q != 16'hFFFF)) flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = 16'h0;
  assign flush_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed vectors push expectations,
// a negedge monitor pops and compares. Honours PIPE_HAZARD_PERF_EN for counter checks.
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  IFID_rs = '0, IFID_rt = '0;
  logic        IFID_usesrt = 1'b0;
  logic [2:0]  IFID_pcsrc = '0;
  logic        branch_taken = 1'b0;
  logic        IDEX_memrd = 1'b0, IDEX_regwr = 1'b0;
  logic [4:0]  IDEX_wa = '0;
  logic        EXMEM_memrd = 1'b0;
  logic [4:0]  EXMEM_rd = '0;
  logic        exc_req = 1'b0;
  logic        PC_wr, IFID_wr, IFID_flush, IDEX_flush, EXMEM_flush, exc_ack;
  logic [15:0] stall_cnt, flush_cnt;

  pipeline_hazard_ctrl dut (
    .clk(clk), .reset(reset),
    .IFID_rs(IFID_rs), .IFID_rt(IFID_rt), .IFID_usesrt(IFID_usesrt),
    .IFID_pcsrc(IFID_pcsrc), .branch_taken(branch_taken),
    .IDEX_memrd(IDEX_memrd), .IDEX_regwr(IDEX_regwr), .IDEX_wa(IDEX_wa),
    .EXMEM_memrd(EXMEM_memrd), .EXMEM_rd(EXMEM_rd), .exc_req(exc_req),
    .PC_wr(PC_wr), .IFID_wr(IFID_wr), .IFID_flush(IFID_flush),
    .IDEX_flush(IDEX_flush), .EXMEM_flush(EXMEM_flush), .exc_ack(exc_ack),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  // ctl = {PC_wr, IFID_wr, IFID_flush, IDEX_flush, EXMEM_flush, exc_ack}
  typedef struct packed {
    logic [31:0] id;
    logic [5:0]  ctl;
    logic [15:0] sc;
    logic [15:0] fc;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  int          vec_id = 0;
  bit          quiet = 1'b0;
  logic [15:0] m_stall = 16'h0;
  logic [15:0] m_flush = 16'h0;

  task automatic drv(input logic [4:0] rs, input logic [4:0] rt, input logic ur,
                     input logic [2:0] pc, input logic bt, input logic mr, input logic rw,
                     input logic [4:0] wa, input logic xm, input logic [4:0] xd,
                     input logic exc, input logic rst, input logic [5:0] ctl);
    exp_t e;
    @(posedge clk);
    #1;
    IFID_rs = rs; IFID_rt = rt; IFID_usesrt = ur; IFID_pcsrc = pc; branch_taken = bt;
    IDEX_memrd = mr; IDEX_regwr = rw; IDEX_wa = wa; EXMEM_memrd = xm; EXMEM_rd = xd;
    exc_req = exc; reset = rst;
    e.id  = vec_id;
    e.ctl = ctl;
`ifdef PIPE_HAZARD_PERF_EN
    e.sc = rst ? 16'h0 : m_stall;
    e.fc = rst ? 16'h0 : m_flush;
`else
    e.sc = 16'h0;
    e.fc = 16'h0;
`endif
    sb_q.push_back(e);
    vec_id++;
    if (rst) begin
      m_stall = 16'h0;
      m_flush = 16'h0;
    end else begin
      if (!ctl[5] && (m_stall != 16'hFFFF)) m_stall = m_stall + 16'd1;
      if (ctl[3] && (m_flush != 16'hFFFF)) m_flush = m_flush + 16'd1;
    end
  endtask

  always @(negedge clk) begin
    exp_t        e;
    logic [5:0]  got;
    if (sb_q.size() > 0) begin
      e   = sb_q.pop_front();
      got = {PC_wr, IFID_wr, IFID_flush, IDEX_flush, EXMEM_flush, exc_ack};
      checks++;
      if (got !== e.ctl) begin
        errors++;
        $display("FAIL ctrl vec %0d: got %b expected %b", e.id, got, e.ctl);
      end
      checks++;
      if (stall_cnt !== e.sc) begin
        errors++;
        $display("FAIL stall_cnt vec %0d: got %h expected %h", e.id, stall_cnt, e.sc);
      end
      checks++;
      if (flush_cnt !== e.fc) begin
        errors++;
        $display("FAIL flush_cnt vec %0d: got %h expected %h", e.id, flush_cnt, e.fc);
      end
      if (!quiet)
        $display("vec %0d: ctl=%b stall_cnt=%0d flush_cnt=%0d", e.id, got, stall_cnt, flush_cnt);
    end
  end

  initial begin
    #5000000;
    $display("FAIL timeout: bench did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    //   rs    rt    ur  pc      bt  mr  rw  wa    xm  xd    exc rst  expected
    drv(5'd0, 5'd0, 0, 3'b000, 0,  0,  0,  5'd0, 0,  5'd0, 0,  1,  6'b001110); // reset
    drv(5'd0, 5'd0, 0, 3'b000, 0,  0,  0,  5'd0, 0,  5'd0, 0,  0,  6'b110000); // idle
    drv(5'd5, 5'd0, 0, 3'b000, 0,  1,  1,  5'd5, 0,  5'd0, 0,  0,  6'b000100); // load-use
    drv(5'd5, 5'd0, 0, 3'b000, 0,  0,  0,  5'd0, 1,  5'd5, 0,  0,  6'b110000); // resumes
    drv(5'd0, 5'd0, 0, 3'b000, 0,  1,  1,  5'd0, 0,  5'd0, 0,  0,  6'b110000); // r0 immune
    drv(5'd1, 5'd7, 1, 3'b001, 1,  1,  1,  5'd7, 0,  5'd0, 0,  0,  6'b000100); // br after load
    drv(5'd1, 5'd7, 1, 3'b001, 1,  0,  0,  5'd0, 1,  5'd7, 0,  0,  6'b000100); // HOLD
    drv(5'd1, 5'd7, 1, 3'b001, 1,  0,  0,  5'd0, 0,  5'd0, 0,  0,  6'b111000); // taken flush
    drv(5'd3, 5'd0, 0, 3'b001, 0,  0,  1,  5'd3, 0,  5'd0, 0,  0,  6'b000100); // br ALU prod
    drv(5'd3, 5'd0, 0, 3'b001, 0,  0,  0,  5'd0, 0,  5'd3, 0,  0,  6'b110000); // not taken
    drv(5'd9, 5'd0, 0, 3'b011, 0,  0,  0,  5'd0, 1,  5'd9, 0,  0,  6'b000100); // jr, load in MEM
    drv(5'd9, 5'd0, 0, 3'b011, 0,  0,  0,  5'd0, 0,  5'd0, 0,  0,  6'b111000); // jr flush
    drv(5'd0, 5'd0, 0, 3'b010, 0,  0,  0,  5'd0, 0,  5'd0, 0,  0,  6'b111000); // j imm
    drv(5'd1, 5'd4, 0, 3'b000, 0,  1,  1,  5'd4, 0,  5'd0, 0,  0,  6'b110000); // rt unused
    drv(5'd2, 5'd0, 0, 3'b001, 0,  0,  1,  5'd2, 1,  5'd2, 0,  0,  6'b000100); // ALU+MEM load
    drv(5'd1, 5'd7, 1, 3'b001, 1,  1,  1,  5'd7, 0,  5'd0, 0,  0,  6'b000100); // enter HOLD
    drv(5'd1, 5'd7, 1, 3'b001, 1,  0,  0,  5'd0, 1,  5'd7, 1,  0,  6'b101111); // exc in HOLD
    drv(5'd0, 5'd0, 0, 3'b000, 0,  0,  0,  5'd0, 0,  5'd0, 1,  0,  6'b110000); // exc held
    drv(5'd0, 5'd0, 0, 3'b000, 0,  0,  0,  5'd0, 0,  5'd0, 0,  0,  6'b110000); // exc low
    drv(5'd5, 5'd0, 0, 3'b000, 0,  1,  1,  5'd5, 0,  5'd0, 1,  0,  6'b101111); // exc over stall
    drv(5'd0, 5'd0, 0, 3'b000, 0,  0,  0,  5'd0, 0,  5'd0, 0,  0,  6'b110000); // RUN
    drv(5'd1, 5'd7, 1, 3'b001, 1,  1,  1,  5'd7, 0,  5'd0, 0,  0,  6'b000100); // enter HOLD
    drv(5'd1, 5'd7, 1, 3'b001, 1,  0,  0,  5'd0, 1,  5'd7, 0,  1,  6'b001110); // reset mid-HOLD
    drv(5'd0, 5'd0, 0, 3'b000, 0,  0,  0,  5'd0, 0,  5'd0, 0,  0,  6'b110000); // RUN after rst
    drv(5'd6, 5'd0, 0, 3'b000, 0,  1,  1,  5'd6, 0,  5'd0, 0,  0,  6'b000100); // load-use
    drv(5'd0, 5'd0, 0, 3'b000, 0,  0,  0,  5'd0, 0,  5'd0, 0,  0,  6'b110000); // count check
`ifdef PIPE_HAZARD_PERF_EN
    quiet = 1'b1;
    for (int i = 0; i < 70000; i++)
      drv(5'd5, 5'd0, 0, 3'b000, 0, 1, 1, 5'd5, 0, 5'd0, 0, 0, 6'b000100);
    drv(5'd0, 5'd0, 0, 3'b000, 0, 0, 0, 5'd0, 0, 5'd0, 0, 0, 6'b110000);
    quiet = 1'b0;
    drv(5'd0, 5'd0, 0, 3'b000, 0, 0, 0, 5'd0, 0, 5'd0, 0, 0, 6'b110000); // saturated
`endif
    for (int i = 0; i < 4 && sb_q.size() > 0; i++) @(negedge clk);
    #1;
    if (sb_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Sequencing controller for the five-stage pipeline that decides, every cycle, whether the front end advances, stalls, or is flushed. It holds the pipeline for hazards that the forwarding unit cannot cover: load-use, and branch/jump-register operands that are not yet forwardable to the ID comparator. It also flushes on taken control transfers and on exceptions. It drives the write-enables and flush strobes of PC, IF/ID and ID/EX, and optionally keeps stall/flush performance counters.

## Interface
- No parameters; all widths are fixed by the 32-register ISA.
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-high reset
- IFID_rs, IFID_rt  in  5 each  source registers of the instruction in ID
- IFID_usesrt  in  1  ID instruction reads rt as an operand (R-type, beq, bne, sw)
- IFID_pcsrc  in  3  PC source of the ID instruction; 001 = branch, 011 = jump-register, 010 = jump-immediate
- branch_taken  in  1  ID comparator result, valid when IFID_pcsrc == 001
- IDEX_memrd, IDEX_regwr  in  1 each  EX instruction is a load / writes a register
- IDEX_wa  in  5  EX destination register (already muxed rt/rd)
- EXMEM_memrd  in  1  MEM instruction is a load
- EXMEM_rd  in  5  MEM destination register
- exc_req  in  1  exception/interrupt request, level
- PC_wr, IFID_wr  out  1 each  load enables
- IFID_flush, IDEX_flush, EXMEM_flush  out  1 each  bubble-insert strobes
- exc_ack  out  1  one-cycle pulse when the exception flush is issued
- stall_cnt, flush_cnt  out  16 each  performance counters

## Operation
- Register 0 never creates a hazard. A match means the register is nonzero and equals IFID_rs, or equals IFID_rt with IFID_usesrt=1.
- Required stall length `need` is the maximum of the rules that apply:
  - Load-use: IDEX_memrd and IDEX_wa matches -> 1.
  - Control operand (pcsrc 001 or 011), ALU producer: IDEX_regwr, not IDEX_memrd, IDEX_wa matches -> 1.
  - Control operand, load in EX: IDEX_memrd and IDEX_wa matches -> 2.
  - Control operand, load in MEM: EXMEM_memrd and EXMEM_rd matches -> 1.
- FSM states: RUN, HOLD (2-bit count `rem`).
  - RUN with need=0: PC_wr=IFID_wr=1. IFID_flush=1 if pcsrc is 010 or 011, or if pcsrc is 001 and branch_taken.
  - RUN with need>0: stall this cycle (PC_wr=IFID_wr=0, IDEX_flush=1, no IFID_flush). If need=2, go to HOLD with rem=1; otherwise stay in RUN.
  - HOLD: stall output set; rem decrements; go to RUN when rem reaches 0. Hazards are not re-evaluated in HOLD.
  - In the first RUN cycle after a stall, hazards are re-evaluated normally. The deferred branch/jump flush happens there.
- Exception has the highest priority in any state:
  - IFID_flush=IDEX_flush=EXMEM_flush=1, PC_wr=1 (vector load), IFID_wr=0, exc_ack=1.
  - Next state is RUN, rem=0.
  - exc_ack pulses only on the rising edge of exc_req.

## Timing
- All control outputs are combinational from the inputs and the state. State, rem, and the counters update on the rising edge of clk.
- Stall latency: load-use costs 1 bubble. A branch after a load in EX costs 2 bubbles. The branch resolves in ID on the cycle after the last stall.
- Reset (asynchronous, any state, including mid-HOLD):
  - State goes to RUN, rem=0, counters=0.
  - While reset is high: PC_wr=IFID_wr=0, all flushes=1, exc_ack=0.
- Counters: stall_cnt +1 per stall cycle; flush_cnt +1 per IFID_flush cycle. Both saturate at 16'hFFFF.

## Configuration
- PIPE_HAZARD_PERF_EN defined: stall_cnt and flush_cnt are implemented as described above.
- PIPE_HAZARD_PERF_EN undefined: no counter registers; stall_cnt and flush_cnt are tied to 16'h0. Control behaviour is identical.

## Test plan
- Load-use: IDEX_memrd=1, IDEX_wa=5, IFID_rs=5 -> exactly 1 cycle with PC_wr=0 and IDEX_flush=1; stall_cnt=1.
- Branch after load: pcsrc=001, IDEX_memrd=1, IDEX_wa=IFID_rt=7, IFID_usesrt=1, branch_taken=1 -> 2 stall cycles, then IFID_flush=1 on the third cycle.
- Register-0 immunity: IDEX_memrd=1, IDEX_wa=0, IFID_rs=0 -> no stall, PC_wr=1.
- Exception mid-HOLD: exc_req rises in HOLD -> same cycle all three flushes=1 and exc_ack=1; next state RUN; a held exc_req yields no second exc_ack.
- Reset mid-HOLD: assert reset between clock edges -> outputs reach their reset values immediately; after deassertion, the first cycle is RUN with PC_wr=1.
- Counter saturation (macro defined): force 70000 stall cycles -> stall_cnt=16'hFFFF. With the macro undefined -> stall_cnt=0.
